// File: rtl/mul_share_ctrl.sv
// rtl/mul_share_ctrl.sv - round-robin sharing of one iterative 8x8 multiplier among N_REQ requesters
// Optional WAIT timeout abort enabled by defining MUL_SHARE_TIMEOUT_EN.
module mul_share_ctrl #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 40
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [8*N_REQ-1:0] req_a,
    input  logic [8*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]   rsp_valid,
    input  logic [N_REQ-1:0]   rsp_ready,
    output logic [15:0]        rsp_p,
    output logic               rsp_err,
    output logic               mul_start,
    output logic [7:0]         mul_a,
    output logic [7:0]         mul_b,
    input  logic               mul_rdy,
    input  logic [15:0]        mul_p,
    output logic               busy
);

    localparam int GW = $clog2(N_REQ);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t           state;
    logic [GW-1:0]    ptr;
    logic [GW-1:0]    gnt;
    logic [GW-1:0]    win_idx;
    logic             win_found;
    logic [GW:0]      scan;
    logic             first_wait;
    logic [N_REQ-1:0] gnt_onehot;
    logic [N_REQ-1:0] win_onehot;

`ifdef MUL_SHARE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
    logic          err_q;
    assign rsp_err = err_q;
`else
    wire unused_timeout = (TIMEOUT > 0);
    assign rsp_err = 1'b0;
`endif

    // First valid requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan = {1'b0, ptr} + (GW+1)'(k);
            if (scan >= (GW+1)'(N_REQ))
                scan = scan - (GW+1)'(N_REQ);
            if (!win_found && req_valid[scan[GW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[GW-1:0];
            end
        end
    end

    assign win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
    assign gnt_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << gnt;
    assign req_ready  = (state == S_IDLE && reset_n && win_found) ? win_onehot : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            ptr        <= '0;
            gnt        <= '0;
            first_wait <= 1'b0;
            rsp_valid  <= '0;
            rsp_p      <= '0;
            mul_start  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            busy       <= 1'b0;
`ifdef MUL_SHARE_TIMEOUT_EN
            wait_cnt   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        mul_a     <= req_a[8*win_idx +: 8];
                        mul_b     <= req_b[8*win_idx +: 8];
                        gnt       <= win_idx;
                        mul_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    mul_start  <= 1'b0;
                    first_wait <= 1'b1;
`ifdef MUL_SHARE_TIMEOUT_EN
                    wait_cnt   <= '0;
`endif
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    // mul_rdy may still be high from the previous product in the first WAIT cycle.
                    first_wait <= 1'b0;
                    if (!first_wait && mul_rdy) begin
                        rsp_p     <= mul_p;
                        rsp_valid <= gnt_onehot;
                        state     <= S_RESP;
`ifdef MUL_SHARE_TIMEOUT_EN
                        err_q     <= 1'b0;
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        rsp_p     <= 16'hFFFF;
                        err_q     <= 1'b1;
                        rsp_valid <= gnt_onehot;
                        state     <= S_RESP;
                    end else begin
                        wait_cnt  <= wait_cnt + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready[gnt]) begin
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        ptr       <= (gnt == GW'(N_REQ - 1)) ? '0 : gnt + 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
